decoder_scan_nxm: RTL

//  Registered, parametrised N-to-2^N one-hot decoder (successor to Decoder3x8).
//  Two modes: DIRECT decodes the select input; SCAN self-sequences through all
//  2^N outputs with a programmable dwell time and a wrap pulse per sweep.

---
 rtl/decoder_pkg.sv | 20 ++
 rtl/decoder_scan_nxm_if.sv | 19 +
 rtl/dwell_timer.sv | 23 ++
 rtl/decoder_scan_nxm.sv | 62 ++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding and clog2 helper for the scanning decoder.
//   ST_IDLE / ST_DIRECT / ST_SCAN  - state encodings
//   state_t                        - FSM state enum built on those encodings
//   clog2(v)                       - ceil(log2(v)), 0 for v <= 1
package decoder_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_DIRECT = ST_DIRECT,
        S_SCAN   = ST_SCAN
    } state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/decoder_scan_nxm_if.sv
// decoder_scan_nxm_if: control inputs and select outputs of the scanning decoder.
//   i_en    decoder enable (0 blanks outputs)
//   i_mode  0 = DIRECT, 1 = SCAN
//   i_in    select index for DIRECT
//   o_out   registered one-hot / one-cold select, OUT_W bits
//   o_idx   index currently driven on o_out
//   o_wrap  one-cycle pulse when a SCAN sweep returns to index 0
//   master: drives i_*, slave: drives o_*
interface decoder_scan_nxm_if #(parameter int SEL_W = 3);
    localparam int OUT_W = 2 ** SEL_W;
    logic             i_en;
    logic             i_mode;
    logic [SEL_W-1:0] i_in;
    logic [OUT_W-1:0] o_out;
    logic [SEL_W-1:0] o_idx;
    logic             o_wrap;
    modport master (output i_en, i_mode, i_in, input o_out, o_idx, o_wrap);
    modport slave (input i_en, i_mode, i_in, output o_out, o_idx, o_wrap);
endinterface

// File: rtl/dwell_timer.sv
// dwell_timer: counts 0..DWELL-1 and flags the terminal count.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       synchronous clear back to 0
//   o_tick      high while the count sits at DWELL-1 (always high when DWELL=1)
module dwell_timer
    import decoder_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
    localparam logic [CW-1:0] TC = CW'(DWELL - 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (i_clr || o_tick) ? '0 : r_cnt + 1'b1;
    end
    assign o_tick = r_cnt == TC;
endmodule

// File: rtl/decoder_scan_nxm.sv
// decoder_scan_nxm: registered N-to-2^N decoder with direct and self-scanning modes.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         decoder_scan_nxm_if slave: i_en/i_mode/i_in in, o_out/o_idx/o_wrap out
//   ACTIVE_LOW  inverts o_out only; o_idx and o_wrap keep their polarity
module decoder_scan_nxm
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    decoder_scan_nxm_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] POL  = {OUT_W{ACTIVE_LOW}};
    localparam logic [SEL_W-1:0] LAST = '1;
    state_t           r_state, w_next;
    logic [SEL_W-1:0] r_idx, w_idx;
    logic [OUT_W-1:0] r_out, w_out;
    logic             r_wrap, w_wrap;
    logic             w_hold, w_tick;
    // Timer only runs while SCAN persists across the edge, so entry and
    // any exit both restart the dwell from 0.
    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!w_hold),
        .o_tick (w_tick)
    );
    always_comb begin
        w_next = !bus.i_en ? S_IDLE : (bus.i_mode ? S_SCAN : S_DIRECT);
        w_hold = (r_state == S_SCAN) && (w_next == S_SCAN);
        w_idx  = '0;
        w_wrap = 1'b0;
        if (w_next == S_DIRECT) begin
            w_idx = bus.i_in;
        end else if (w_hold) begin
            // Index width is exactly SEL_W, so LAST+1 rolls over to 0.
            w_idx  = w_tick ? r_idx + 1'b1 : r_idx;
            w_wrap = w_tick && (r_idx == LAST);
        end
        w_out = (w_next == S_IDLE) ? POL : POL ^ (OUT_W'(1) << w_idx);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_out   <= POL;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx;
            r_out   <= w_out;
            r_wrap  <= w_wrap;
        end
    end
    assign bus.o_out  = r_out;
    assign bus.o_idx  = r_idx;
    assign bus.o_wrap = r_wrap;
endmodule
